// File: rtl/serial_word_rx.sv
// -----------------------------------------------------------------------------
// serial_word_rx
//
// Serial-to-parallel frame receiver. Frame on sin, one bit per bit_en tick:
//   start (0), W data bits LSB-first, even-parity bit, stop (1).
// The received word is committed to a held parallel output together with its
// parity/framing error flags, and handed over via a dvalid/ack handshake.
//
// Ports
//   clk      in   system clock, rising edge
//   CR       in   asynchronous active-low clear
//   bit_en   in   bit-rate strobe; sin is sampled only when bit_en=1
//   sin      in   serial line, idles high
//   ack      in   consumer acknowledge for the held word
//   dout     out  [W-1:0] last committed word, bit 0 = first data bit
//   dvalid   out  dout holds an unacknowledged word
//   perr     out  parity error flag for the word on dout
//   ferr     out  framing error flag (stop bit was 0) for the word on dout
//   overrun  out  sticky: a word was committed over an unacknowledged one
// -----------------------------------------------------------------------------
module serial_word_rx #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         CR,
  input  logic         bit_en,
  input  logic         sin,
  input  logic         ack,
  output logic [W-1:0] dout,
  output logic         dvalid,
  output logic         perr,
  output logic         ferr,
  output logic         overrun
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t         state_q,   state_d;
  logic [CW-1:0]  cnt_q,     cnt_d;
  logic [W-1:0]   shreg_q,   shreg_d;
  logic           par_bad_q, par_bad_d;
  logic [W-1:0]   dout_q,    dout_d;
  logic           dvalid_q,  dvalid_d;
  logic           perr_q,    perr_d;
  logic           ferr_q,    ferr_d;
  logic           overrun_q, overrun_d;
  logic           commit;

  // Next-state and output-register logic.
  always_comb begin
    // NOTE: every signal gets a hold-value default first so no path through
    // the case/if tree leaves one unassigned, which would infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    par_bad_d = par_bad_q;
    dout_d    = dout_q;
    dvalid_d  = dvalid_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    overrun_d = overrun_q;
    commit    = 1'b0;

    if (bit_en) begin
      case (state_q)
        IDLE: begin
          if (!sin) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          // LSB arrives first, so shift right and insert at the top.
          shreg_d = {sin, shreg_q[W-1:1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = PAR;
        end
        PAR: begin
          par_bad_d = (^shreg_q) ^ sin;
          state_d   = STOP;
        end
        STOP: begin
          // The stop tick only closes the frame; a start bit is looked for
          // from the next tick onward, even if this stop bit was 0.
          commit  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // Commit has priority over ack: a new word arriving in the ack cycle
    // stays valid and leaves overrun untouched.
    if (commit) begin
      dout_d   = shreg_q;
      perr_d   = par_bad_q;
      ferr_d   = ~sin;
      dvalid_d = 1'b1;
      if (dvalid_q && !ack) overrun_d = 1'b1;
    end else if (ack && dvalid_q) begin
      dvalid_d  = 1'b0;
      overrun_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge CR) begin
    if (!CR) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      // NOTE: the shift register is cleared along with the control state so a
      // partial frame never leaks into a later word.
      shreg_q   <= '0;
      par_bad_q <= 1'b0;
      dout_q    <= '0;
      dvalid_q  <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      par_bad_q <= par_bad_d;
      dout_q    <= dout_d;
      dvalid_q  <= dvalid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      overrun_q <= overrun_d;
    end
  end

  assign dout    = dout_q;
  assign dvalid  = dvalid_q;
  assign perr    = perr_q;
  assign ferr    = ferr_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_serial_word_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_word_rx
//
// Self-checking bench for serial_word_rx (W=4). Inputs are driven on the
// falling clock edge and outputs are compared on falling edges, so the DUT
// samples and updates cleanly on the rising edge in between.
// Sections: reset, first-commit latency, a table of frames, hand-written
// corner sequences (framing error, mid-frame clear, slow strobe), then
// randomized frames against a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_serial_word_rx;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         CR;
  logic         bit_en;
  logic         sin;
  logic         ack;
  logic [W-1:0] dout;
  logic         dvalid;
  logic         perr;
  logic         ferr;
  logic         overrun;

  int n_tests = 0;
  int n_fail  = 0;
  bit at_edge = 1'b0;  // already sitting on a falling edge, inputs not yet driven

  // Frame-level reference state.
  logic [W-1:0] m_dout;
  bit           m_dvalid, m_perr, m_ferr, m_ovr;

  typedef struct {
    logic [W-1:0] data;
    bit           par;
    bit           stop;
    bit           ack_c;      // ack asserted on the stop tick
    bit           ack_after;  // one-cycle ack pulse after the commit
    logic [W-1:0] e_dout;
    bit           e_perr;
    bit           e_ferr;
    bit           e_ovr;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  serial_word_rx #(.W(W)) dut (
    .clk     (clk),
    .CR      (CR),
    .bit_en  (bit_en),
    .sin     (sin),
    .ack     (ack),
    .dout    (dout),
    .dvalid  (dvalid),
    .perr    (perr),
    .ferr    (ferr),
    .overrun (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] e_dout, input bit e_dv,
                           input bit e_pe, input bit e_fe, input bit e_ov);
    check({tag, ".dout"},    32'(dout),    32'(e_dout));
    check({tag, ".dvalid"},  32'(dvalid),  32'(e_dv));
    check({tag, ".perr"},    32'(perr),    32'(e_pe));
    check({tag, ".ferr"},    32'(ferr),    32'(e_fe));
    check({tag, ".overrun"}, 32'(overrun), 32'(e_ov));
  endtask

  // Drive one cycle's inputs on a falling edge.
  task automatic drive(input bit en, input bit s, input bit a);
    if (!at_edge) @(negedge clk);
    at_edge = 1'b0;
    bit_en  = en;
    sin     = s;
    ack     = a;
  endtask

  // Advance to the next falling edge and park the inputs idle there.
  task automatic settle();
    @(negedge clk);
    bit_en  = 1'b0;
    sin     = 1'b1;
    ack     = 1'b0;
    at_edge = 1'b1;
  endtask

  // One frame; 'gap' non-tick cycles with random sin precede every tick.
  task automatic send_frame(input logic [W-1:0] data, input bit par, input bit stop,
                            input int gap, input bit ack_c);
    logic [W+2:0] bits;
    bits = {stop, par, data, 1'b0};
    for (int i = 0; i < W + 3; i++) begin
      for (int g = 0; g < gap; g++) drive(1'b0, 1'($urandom), 1'b0);
      drive(1'b1, bits[i], (i == W + 2) ? ack_c : 1'b0);
    end
  endtask

  task automatic ack_pulse();
    drive(1'b0, 1'b1, 1'b1);
    settle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Table: starts with dvalid=0, overrun=0.
    vecs[0] = '{4'hD, 1'b1, 1'b1, 1'b0, 1'b1, 4'hD, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{4'hD, 1'b0, 1'b1, 1'b0, 1'b1, 4'hD, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{4'hD, 1'b1, 1'b0, 1'b0, 1'b1, 4'hD, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{4'hA, 1'b0, 1'b1, 1'b0, 1'b1, 4'hA, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{4'h6, 1'b0, 1'b1, 1'b1, 1'b1, 4'h6, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{4'h7, 1'b1, 1'b0, 1'b0, 1'b0, 4'h7, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b1};

    CR     = 1'b0;
    bit_en = 1'b0;
    sin    = 1'b1;
    ack    = 1'b0;
    repeat (2) @(negedge clk);
    check_all("reset", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    CR      = 1'b1;
    at_edge = 1'b1;

    // First frame: dvalid must still be low while the stop bit is on the line.
    send_frame(4'hD, 1'b1, 1'b1, 0, 1'b0);
    check("latency.dvalid_pre", 32'(dvalid), 32'd0);
    settle();
    check_all("first", 4'hD, 1'b1, 1'b0, 1'b0, 1'b0);
    ack_pulse();
    check_all("first_ack", 4'hD, 1'b0, 1'b0, 1'b0, 1'b0);

    // Table-driven frames.
    foreach (vecs[i]) begin
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, 0, vecs[i].ack_c);
      settle();
      check_all($sformatf("vec%0d", i), vecs[i].e_dout, 1'b1, vecs[i].e_perr,
                vecs[i].e_ferr, vecs[i].e_ovr);
      if (vecs[i].ack_after) begin
        ack_pulse();
        check_all($sformatf("vec%0d_ack", i), vecs[i].e_dout, 1'b0, vecs[i].e_perr,
                  vecs[i].e_ferr, 1'b0);
      end
    end

    // Framing error, then a long run of idle-high ticks: no second commit.
    send_frame(4'hD, 1'b1, 1'b0, 0, 1'b0);
    settle();
    check_all("ferr", 4'hD, 1'b1, 1'b0, 1'b1, 1'b0);
    ack_pulse();
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b0);
    settle();
    check_all("ferr_idle", 4'hD, 1'b0, 1'b0, 1'b1, 1'b0);
    // ack while nothing is valid changes nothing.
    ack_pulse();
    check_all("ack_idle", 4'hD, 1'b0, 1'b0, 1'b1, 1'b0);

    // Build up dvalid/overrun, then clear in the middle of a frame.
    send_frame(4'h5, 1'b0, 1'b1, 0, 1'b0);
    send_frame(4'hA, 1'b0, 1'b1, 0, 1'b0);  // back-to-back start after stop
    settle();
    check_all("b2b_ovr", 4'hA, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    bit_en = 1'b0;
    CR     = 1'b0;
    #1;
    check_all("clr_async", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    bit_en = 1'b1;
    sin    = 1'b0;
    repeat (2) @(negedge clk);
    check_all("clr_hold", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    CR      = 1'b1;
    at_edge = 1'b1;
    send_frame(4'h3, 1'b0, 1'b1, 0, 1'b0);
    settle();
    check_all("after_clr", 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);

    // Slow strobe: one tick every third cycle, sin toggling in between.
    ack_pulse();
    send_frame(4'hD, 1'b1, 1'b1, 2, 1'b0);
    settle();
    check_all("slow", 4'hD, 1'b1, 1'b0, 1'b0, 1'b0);
    ack_pulse();
    check_all("slow_ack", 4'hD, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized frames against the frame-level model.
    m_dout   = 4'hD;
    m_dvalid = 1'b0;
    m_perr   = 1'b0;
    m_ferr   = 1'b0;
    m_ovr    = 1'b0;
    for (int n = 0; n < 60; n++) begin
      logic [W-1:0] data;
      bit par_good, stop, ack_c, par;
      int gap, post;
      data     = W'($urandom);
      par_good = ($urandom_range(0, 3) != 0);
      stop     = ($urandom_range(0, 4) != 0);
      ack_c    = ($urandom_range(0, 3) == 0);
      gap      = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      par      = (^data) ^ !par_good;

      send_frame(data, par, stop, gap, ack_c);
      settle();
      if (m_dvalid && !ack_c) m_ovr = 1'b1;
      m_dvalid = 1'b1;
      m_dout   = data;
      m_perr   = !par_good;
      m_ferr   = !stop;
      check_all($sformatf("rnd%0d", n), m_dout, m_dvalid, m_perr, m_ferr, m_ovr);

      post = int'($urandom_range(0, 3));
      if (post == 1 || post == 3) begin
        ack_pulse();
        if (m_dvalid) begin
          m_dvalid = 1'b0;
          m_ovr    = 1'b0;
        end
        check_all($sformatf("rnd%0d_ack", n), m_dout, m_dvalid, m_perr, m_ferr, m_ovr);
      end else if (post == 2) begin
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) drive(1'b1, 1'b1, 1'b0);
        settle();
        check_all($sformatf("rnd%0d_idle", n), m_dout, m_dvalid, m_perr, m_ferr, m_ovr);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
